// File: rtl/bist_addr_counter_pkg.sv
// Shared definitions for the RAM BIST address sequencer.
//   state_t : FSM state encoding (IDLE / RUN / DONE)
//   DIR_UP  : ascending sweep, 0 -> MAX
//   DIR_DN  : descending sweep, MAX -> 0
package bist_addr_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/bist_addr_counter_full_adder.sv
// One-bit full adder cell, chained by the address sequencer into a ripple adder.
//   a, b  : operand bits
//   cin   : carry in from the previous (less significant) cell
//   sum   : sum bit
//   cout  : carry out to the next cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bist_addr_counter.sv
// RAM BIST address sequencer. Walks 0..2**ADDR_W-1 up or down, one address per
// accepted step. The next address and the terminal condition both come from a
// single ripple chain of full_adder cells.
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous, active-high
//   start  : begin a sweep (IDLE only); dir sampled with it
//   dir    : 0 = up, 1 = down
//   step   : advance one address (RUN only)
//   abort  : leave RUN without a done pulse; wins over step
//   addr   : registered RAM address
//   busy   : high in RUN
//   last   : high in RUN while addr is the sweep's terminal address
//   done   : one-cycle pulse after the terminal step
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | waiting for start, addr holds its last value
//   ST_RUN  | sweeping, addr advances on each step
//   ST_DONE | single cycle after the terminal step, done=1
module bist_addr_counter
  import bist_addr_counter_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic              step,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              last,
  output logic              done
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_next;
  logic              dir_q, dir_next;

  logic [ADDR_W-1:0] op_y;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W:0]   carry;
  logic              terminal;

  // up: addr + 0 + 1; down: addr + all-ones + 0 == addr - 1
  assign op_y     = {ADDR_W{dir_q}};
  assign carry[0] = ~dir_q;

  for (genvar i = 0; i < ADDR_W; i++) begin : g_ripple
    full_adder u_fa (
      .a    (addr[i]),
      .b    (op_y[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Carry-out marks wrap: set when MAX+1 overflows going up, clear only when
  // 0-1 borrows going down.
  assign terminal = (dir_q == DIR_UP) ? carry[ADDR_W] : ~carry[ADDR_W];

  always_comb begin
    state_next = state;
    addr_next  = addr;
    dir_next   = dir_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          dir_next   = dir;
          addr_next  = {ADDR_W{dir}};
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (step) begin
          if (terminal) state_next = ST_DONE;
          else          addr_next  = sum;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      dir_q <= DIR_UP;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      dir_q <= dir_next;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign last = busy & terminal;

endmodule

// File: tb/tb_bist_addr_counter.sv
// Directed-vector bench for bist_addr_counter (ADDR_W=3). Each vector drives
// one cycle of inputs and queues the outputs expected after the next edge; a
// monitor pops and compares after every rising edge.
module tb_bist_addr_counter;

  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              dir = 1'b0;
  logic              step = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              busy, last, done;

  typedef struct {
    string             tag;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              last;
    logic              done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bist_addr_counter #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .dir   (dir),
    .step  (step),
    .abort (abort),
    .addr  (addr),
    .busy  (busy),
    .last  (last),
    .done  (done)
  );

  task automatic v(input string tag, input logic r, input logic s, input logic d,
                   input logic st, input logic ab, input int a, input logic b,
                   input logic l, input logic dn);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; dir = d; step = st; abort = ab;
    e.tag  = tag;
    e.addr = ADDR_W'(a);
    e.busy = b;
    e.last = l;
    e.done = dn;
    exp_q.push_back(e);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (addr !== e.addr || busy !== e.busy || last !== e.last || done !== e.done) begin
          n_fail++;
          $display("FAIL %s: got addr=%0d busy=%b last=%b done=%b, want addr=%0d busy=%b last=%b done=%b",
                   e.tag, addr, busy, last, done, e.addr, e.busy, e.last, e.done);
        end
      end
    end
  end

  initial begin
    int guard;
    // reset
    v("rst0", 1,0,0,0,0, 0,0,0,0);
    v("rst1", 1,0,0,0,0, 0,0,0,0);
    v("idle", 0,0,0,1,1, 0,0,0,0);

    // 1: up sweep, step every cycle
    v("up_start", 0,1,0,0,0, 0,1,0,0);
    for (int i = 1; i <= 7; i++) v("up_step", 0,0,0,1,0, i,1,(i == 7),0);
    v("up_done", 0,0,0,1,0, 7,0,0,1);
    v("up_idle", 0,0,0,0,0, 7,0,0,0);

    // 2: down sweep
    v("dn_start", 0,1,1,0,0, 7,1,0,0);
    for (int i = 6; i >= 0; i--) v("dn_step", 0,0,0,1,0, i,1,(i == 0),0);
    v("dn_done", 0,0,0,1,0, 0,0,0,1);
    v("dn_idle", 0,0,0,0,0, 0,0,0,0);

    // 3+4: gapped steps up to 4, then abort with step in the same cycle
    v("gap_start", 0,1,0,0,0, 0,1,0,0);
    for (int i = 1; i <= 4; i++) begin
      v("gap_hold", 0,0,0,0,0, i-1,1,0,0);
      v("gap_hold", 0,0,0,0,0, i-1,1,0,0);
      v("gap_step", 0,0,0,1,0, i,1,0,0);
    end
    v("abort", 0,0,0,1,1, 4,0,0,0);
    v("abort_idle", 0,0,0,1,0, 4,0,0,0);

    // 5: reset mid-sweep at addr 5 with step
    v("r5_start", 0,1,0,0,0, 0,1,0,0);
    for (int i = 1; i <= 5; i++) v("r5_step", 0,0,0,1,0, i,1,0,0);
    v("r5_reset", 1,0,0,1,0, 0,0,0,0);
    v("r5_idle", 0,0,0,0,0, 0,0,0,0);

    // 6: start held through RUN and DONE; dir changes ignored in RUN
    v("h_start", 0,1,0,0,1, 0,1,0,0);
    for (int i = 1; i <= 7; i++) v("h_step", 0,1,1,1,0, i,1,(i == 7),0);
    v("h_done", 0,1,1,1,0, 7,0,0,1);
    v("h_idle", 0,1,1,0,0, 7,0,0,0);
    v("h_restart", 0,1,1,0,0, 7,1,0,0);
    v("h_dn_step", 0,1,0,1,0, 6,1,0,0);
    v("h_abort", 0,0,0,0,1, 6,0,0,0);
    v("h_end", 0,0,0,0,0, 6,0,0,0);

    @(negedge clk);
    start = 1'b0; step = 1'b0; abort = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
